// File: rtl/l1_l2_arb_pkg.sv
// l1_l2_arb_pkg
//   Shared types and constants for the L1I/L1D -> L2 arbiter:
//   FSM state enum, requesting-port id enum and grant-counter width.
package l1_l2_arb_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_I  = 2'd1,
        ST_BUSY_D  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk, rst_n   clock, async active-low reset (count -> 0)
//     i_clr        synchronous clear; wins over i_inc
//     i_inc        increment by one, holds at all-ones
//     o_count      current count
module sat_counter
    import l1_l2_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter
//   Arbitrates L1I line fills and L1D fills/writebacks onto a single L2
//   port with at most one outstanding transaction. Ties go to the port
//   that was not granted last.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     i_addr/i_read              L1I fill request (held until i_resp)
//     i_rdata/i_resp             L1I fill data, one-cycle completion pulse
//     d_addr/d_read/d_write      L1D request (both high = write)
//     d_wdata                    L1D writeback line
//     d_rdata/d_resp             L1D fill data, one-cycle completion pulse
//     l2_addr/l2_read/l2_write   registered L2 request
//     l2_wdata                   registered L2 write line
//     l2_rdata/l2_resp           L2 read data and completion pulse
//     i/d_grant_clear            synchronous clear of grant counters
//     i/d_grant_count            saturating grant counters
module l1_l2_arbiter
    import l1_l2_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_read,
    output logic              l2_write,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    input  logic              i_grant_clear,
    input  logic              d_grant_clear,
    output logic [CNT_W-1:0]  i_grant_count,
    output logic [CNT_W-1:0]  d_grant_count
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    port_e             r_last;
    logic [ADDR_W-1:0] r_l2_addr;
    logic              r_l2_read;
    logic              r_l2_write;
    logic [LINE_W-1:0] r_l2_wdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_busy;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    assign w_busy  = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and grant decision; grants only happen from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_i_req && w_d_req) begin
                    if (r_last == PORT_I) w_grant_d = 1'b1;
                    else                  w_grant_i = 1'b1;
                end else if (w_i_req) begin
                    w_grant_i = 1'b1;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_i)      w_state_nxt = ST_BUSY_I;
                else if (w_grant_d) w_state_nxt = ST_BUSY_D;
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (l2_resp) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: the resp pulse is a straight qualification of l2_resp by the
    // owning BUSY state, so a stray l2_resp outside BUSY never leaks through.
    always_comb begin
        i_resp = (r_state == ST_BUSY_I) && l2_resp;
        d_resp = (r_state == ST_BUSY_D) && l2_resp;
    end

    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

    // L2 request registers, loaded on the grant edge and held until the
    // completion edge. wdata only changes on a D grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l2_addr  <= '0;
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
            r_l2_wdata <= '0;
            r_last     <= PORT_I;
        end else if (w_grant_i) begin
            r_l2_addr  <= i_addr;
            r_l2_read  <= 1'b1;
            r_l2_write <= 1'b0;
            r_last     <= PORT_I;
        end else if (w_grant_d) begin
            r_l2_addr  <= d_addr;
            // read+write together is a writeback
            r_l2_read  <= ~d_write;
            r_l2_write <= d_write;
            r_l2_wdata <= d_wdata;
            r_last     <= PORT_D;
        end else if (w_busy && l2_resp) begin
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
        end
    end

    assign l2_addr  = r_l2_addr;
    assign l2_read  = r_l2_read;
    assign l2_write = r_l2_write;
    assign l2_wdata = r_l2_wdata;

    sat_counter #(.W(CNT_W)) u_i_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (i_grant_clear),
        .i_inc   (w_grant_i),
        .o_count (i_grant_count)
    );

    sat_counter #(.W(CNT_W)) u_d_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (d_grant_clear),
        .i_inc   (w_grant_d),
        .o_count (d_grant_count)
    );

endmodule
